// File: rtl/roic_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : roic_stream_gen
// Description : Readout-IC test stream generator. Emits frames of BLOCK_LEN
//               sample blocks with optional inter-block gaps and tagged data.
//               Optional feature macro: ROIC_GEN_ERR_INJECT_EN (channel-marker
//               drop on the block following an err_inject pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module roic_stream_gen #(
    parameter int DATA_WIDTH = 24,
    parameter int BLOCK_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync,
    input  logic                  start,
    input  logic                  stop,
    input  logic [7:0]            cfg_num_blocks,
    input  logic [7:0]            cfg_gap,
    input  logic                  err_inject,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  channel_detected,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            block_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] c_last_idx = 8'(BLOCK_LEN - 1);

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_idx, w_idx_nxt;
    logic [7:0]            r_block_cnt, w_cnt_nxt;
    logic [7:0]            r_gap_cnt, w_gap_cnt_nxt;
    logic [7:0]            r_num_blocks, w_num_nxt;
    logic [7:0]            r_gap, w_gap_nxt;
    logic                  r_stop_req, w_stop_nxt;
    logic                  r_err_flag, w_err_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_chdet, w_chdet_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;

    logic                  w_clear;
    logic                  w_err_in;
    logic                  w_emit;
    logic [7:0]            w_emit_idx;
    logic [7:0]            w_emit_blk;
    logic [7:0]            w_cnt_inc;
    logic                  w_last_block;

    assign w_clear   = !rst_n || sync;
    assign w_cnt_inc = r_block_cnt + 8'd1;

`ifdef ROIC_GEN_ERR_INJECT_EN
    assign w_err_in = err_inject;
`else
    logic w_unused_err_inject;
    assign w_unused_err_inject = err_inject;
    assign w_err_in            = 1'b0;
`endif

    // A pending stop (level or latched pulse) or reaching the programmed count ends the frame
    assign w_last_block = ((r_num_blocks != 8'd0) && (w_cnt_inc == r_num_blocks))
                          || stop || r_stop_req;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_block_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_num_blocks <= '0;
            r_gap        <= '0;
            r_stop_req   <= 1'b0;
            r_err_flag   <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_chdet      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_block_cnt  <= w_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_num_blocks <= w_num_nxt;
            r_gap        <= w_gap_nxt;
            r_stop_req   <= w_stop_nxt;
            r_err_flag   <= w_err_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_chdet      <= w_chdet_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state logic computes what the registered outputs present next cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_block_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_num_nxt     = r_num_blocks;
        w_gap_nxt     = r_gap;
        w_stop_nxt    = r_stop_req | stop;
        w_err_nxt     = r_err_flag | w_err_in;
        w_data_nxt    = '0;
        w_valid_nxt   = 1'b0;
        w_chdet_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_emit        = 1'b0;
        w_emit_idx    = '0;
        w_emit_blk    = r_block_cnt;

        case (r_state)
            ST_IDLE: begin
                w_stop_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_num_nxt   = cfg_num_blocks;
                    w_gap_nxt   = cfg_gap;
                    w_stop_nxt  = stop;
                    w_emit      = 1'b1;
                    w_emit_blk  = '0;
                end
            end
            ST_RUN: begin
                if (r_idx == c_last_idx) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_last_block) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (r_gap != 8'd0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = r_gap;
                    end else begin
                        w_emit     = 1'b1;
                        w_emit_blk = w_cnt_inc;
                    end
                end else begin
                    w_emit     = 1'b1;
                    w_emit_idx = r_idx + 8'd1;
                end
            end
            ST_GAP: begin
                if (stop || r_stop_req) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_gap_cnt == 8'd1) begin
                    w_state_nxt = ST_RUN;
                    w_emit      = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase

        if (w_emit) begin
            w_valid_nxt                      = 1'b1;
            w_idx_nxt                        = w_emit_idx;
            w_data_nxt[15:8]                 = w_emit_blk;
            w_data_nxt[6]                    = w_emit_blk[0];
            w_data_nxt[DATA_WIDTH-1 -: 8]    = w_emit_idx;
            if (w_emit_idx == 8'd0) begin
                // A latched error request suppresses exactly one block marker
                w_chdet_nxt = !r_err_flag;
                if (r_err_flag) begin
                    w_err_nxt = w_err_in;
                end
            end
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign data_out         = r_data;
    assign valid_out        = r_valid;
    assign channel_detected = r_chdet;
    assign busy             = r_busy;
    assign done             = r_done;
    assign block_cnt        = r_block_cnt;

endmodule
`default_nettype wire

// File: tb/tb_roic_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_roic_stream_gen
// Description : Directed self-checking bench for roic_stream_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roic_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  cfg_num_blocks = '0;
    logic [7:0]  cfg_gap = '0;
    logic        err_inject = 1'b0;
    logic [23:0] data_out;
    logic        valid_out;
    logic        channel_detected;
    logic        busy;
    logic        done;
    logic [7:0]  block_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    roic_stream_gen #(.DATA_WIDTH(24), .BLOCK_LEN(256)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sync             (sync),
        .start            (start),
        .stop             (stop),
        .cfg_num_blocks   (cfg_num_blocks),
        .cfg_gap          (cfg_gap),
        .err_inject       (err_inject),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .channel_detected (channel_detected),
        .busy             (busy),
        .done             (done),
        .block_cnt        (block_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next clock cycle
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [23:0] exp_data(input int idx, input int blk);
        logic [23:0] d;
        d        = '0;
        d[23:16] = idx[7:0];
        d[15:8]  = blk[7:0];
        d[6]     = blk[0];
        return d;
    endfunction

    // Checks one full block starting at the current cycle; leaves the bench on its last sample
    task automatic expect_block(input int blk);
        for (int i = 0; i < 256; i++) begin
            if (i != 0) step();
            check($sformatf("blk%0d_valid_%0d", blk, i), 32'(valid_out), 32'd1);
            check($sformatf("blk%0d_data_%0d", blk, i), 32'(data_out), 32'(exp_data(i, blk)));
            check($sformatf("blk%0d_chdet_%0d", blk, i), 32'(channel_detected), 32'(i == 0));
        end
    endtask

    initial begin
        int cyc, nval, ninv, nch, last_idx, last_blk;
        logic hit;
        logic [7:0] rec [0:3];

        @(negedge clk);
        step();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_cnt", 32'(block_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Two back-to-back blocks
        cfg_num_blocks = 8'd2; cfg_gap = 8'd0; start = 1'b1;
        step();
        start = 1'b0; cfg_num_blocks = 8'd7; cfg_gap = 8'd9;
        expect_block(0);
        step();
        expect_block(1);
        step();
        check("a_done", 32'(done), 32'd1);
        check("a_done_valid", 32'(valid_out), 32'd0);
        check("a_done_busy", 32'(busy), 32'd1);
        check("a_cnt", 32'(block_cnt), 32'd2);
        step();
        check("a_idle_busy", 32'(busy), 32'd0);
        check("a_idle_done", 32'(done), 32'd0);

        // Three blocks with 4-cycle gaps, plus a stray start while busy
        cfg_num_blocks = 8'd3; cfg_gap = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1; nval = 0; ninv = 0; nch = 0;
        while (!done && cyc < 2000) begin
            if (valid_out) nval++; else ninv++;
            if (channel_detected) nch++;
            start = (cyc == 300);
            step();
            cyc++;
        end
        start = 1'b0;
        check("b_span", 32'(cyc), 32'd777);
        check("b_valids", 32'(nval), 32'd768);
        check("b_gaps", 32'(ninv), 32'd8);
        check("b_chdet", 32'(nch), 32'd3);
        check("b_cnt", 32'(block_cnt), 32'd3);
        step();
        check("b_done_width", 32'(done), 32'd0);

        // Continuous mode, stop at sample 100 of block 5
        cfg_num_blocks = 8'd0; cfg_gap = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0; hit = 1'b0;
        while (!hit && cyc < 3000) begin
            if (valid_out && data_out[23:16] == 8'd100 && data_out[15:8] == 8'd5) hit = 1'b1;
            else begin step(); cyc++; end
        end
        check("c_reach", 32'(hit), 32'd1);
        stop = 1'b1;
        cyc = 0; last_idx = -1; last_blk = -1;
        do begin
            step();
            cyc++;
            if (valid_out) begin
                last_idx = int'(data_out[23:16]);
                last_blk = int'(data_out[15:8]);
            end
        end while (!done && cyc < 400);
        check("c_stop_lat", 32'(cyc), 32'd156);
        check("c_last_idx", 32'(last_idx), 32'd255);
        check("c_last_blk", 32'(last_blk), 32'd5);
        check("c_cnt", 32'(block_cnt), 32'd6);
        stop = 1'b0;
        step();
        check("c_idle", 32'(busy), 32'd0);

        // Sync abort at sample 37 of block 1
        cfg_num_blocks = 8'd0; cfg_gap = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0; hit = 1'b0;
        while (!hit && cyc < 1000) begin
            if (valid_out && data_out[23:16] == 8'd37 && data_out[15:8] == 8'd1) hit = 1'b1;
            else begin step(); cyc++; end
        end
        check("d_reach", 32'(hit), 32'd1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("d_valid", 32'(valid_out), 32'd0);
        check("d_busy", 32'(busy), 32'd0);
        check("d_done", 32'(done), 32'd0);
        check("d_cnt", 32'(block_cnt), 32'd0);
        check("d_data", 32'(data_out), 32'd0);
        nval = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_out || done || busy) nval++;
        end
        check("d_quiet", 32'(nval), 32'd0);

        // Start and stop together: exactly one block
        cfg_num_blocks = 8'd0; cfg_gap = 8'd0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        cyc = 0; nval = 0; nch = 0;
        while (!done && cyc < 600) begin
            if (valid_out) nval++;
            if (channel_detected) nch++;
            step();
            cyc++;
        end
        check("e_valids", 32'(nval), 32'd256);
        check("e_chdet", 32'(nch), 32'd1);
        check("e_done", 32'(done), 32'd1);
        check("e_cnt", 32'(block_cnt), 32'd1);
        step();

        // Sync beats start in the same cycle
        start = 1'b1; sync = 1'b1;
        step();
        start = 1'b0; sync = 1'b0;
        check("f_busy", 32'(busy), 32'd0);
        check("f_valid", 32'(valid_out), 32'd0);
        step();
        check("f_still_idle", 32'(busy), 32'd0);

        // Error injection during block 0
        for (int b = 0; b < 4; b++) rec[b] = 8'hEE;
        cfg_num_blocks = 8'd3; cfg_gap = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 1000) begin
            if (valid_out && data_out[23:16] == 8'd0) rec[data_out[9:8]] = 8'(channel_detected);
            err_inject = valid_out && data_out[23:16] == 8'd10 && data_out[15:8] == 8'd0;
            step();
            cyc++;
        end
        err_inject = 1'b0;
        check("g_done", 32'(done), 32'd1);
        check("g_blk0", 32'(rec[0]), 32'd1);
`ifdef ROIC_GEN_ERR_INJECT_EN
        check("g_blk1", 32'(rec[1]), 32'd0);
`else
        check("g_blk1", 32'(rec[1]), 32'd1);
`endif
        check("g_blk2", 32'(rec[2]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
